eth_tx_fcs_ctrl: RTL and testbench
==================================

# eth_tx_fcs_ctrl

Transmit-side frame sequencer for the 1G Ethernet MAC datapath, between the frame source and the GMII byte serializer. It accepts a byte stream with end-of-frame marking and zero-pads short frames to the minimum payload. It drives a byte-wide CRC-32 engine over every emitted byte, appends the 4-byte FCS, then enforces the inter-frame gap before accepting the next frame.

## Interface
- MIN_DATA, 60: minimum pre-FCS bytes per frame; shorter frames are zero-padded to this length.
- IFG_CYCLES, 12: idle cycles enforced after the last FCS byte is accepted.
- clk  in  1  single clock domain; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid && s_ready.
- s_data  in  8  input byte.
- s_last  in  1  marks final source byte of a frame.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  8  output byte (data, pad, or FCS).
- m_last  out  1  high on the 4th FCS byte only.
- tx_busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the last FCS byte is accepted.
- frame_len  out  16  total bytes emitted including pad and FCS; valid with frame_done, held until the next pulse.

## Operation
- States: IDLE, DATA, PAD, FCS, IFG.
- The output is a single register stage (m_valid/m_data/m_last). It loads whenever it is empty or being accepted in the same cycle ("slot free").
- IDLE:
  - CRC register is held at 0xFFFFFFFF; byte count is 0.
  - s_ready = slot free.
  - The first accepted byte moves the state to DATA.
- DATA:
  - s_ready = slot free.
  - Each accepted byte is loaded to the output, folded into the CRC, and increments the count.
  - On an accepted s_last byte: if count+1 < MIN_DATA, go to PAD; otherwise go to FCS.
- PAD:
  - s_ready = 0.
  - Emits 0x00 bytes, each folded into the CRC and counted, until count reaches MIN_DATA; then go to FCS.
- FCS:
  - s_ready = 0.
  - Emits ~C[7:0], ~C[15:8], ~C[23:16], ~C[31:24] from the final CRC value C, which is frozen on entry.
  - m_last is set on the 4th byte. When that byte is accepted: frame_done pulses, frame_len is updated, and the state moves to IFG.
- IFG:
  - s_ready = 0, m_valid = 0.
  - Counts IFG_CYCLES cycles, then returns to IDLE.
- CRC: reflected CRC-32 (poly 0xEDB88320), byte-wide, LSB-first, init 0xFFFFFFFF. With this, ~C equals the standard zlib CRC-32 value.
- Byte count and frame_len are 16 bits and saturate at 0xFFFF. Saturation does not affect CRC or FCS emission.
- s_data and s_last are ignored unless s_valid && s_ready.

## Timing
- Reset: state=IDLE, m_valid=0, m_data=0, m_last=0, s_ready=0 during reset, tx_busy=0, frame_done=0, frame_len=0, CRC=0xFFFFFFFF.
- Latency: an accepted input byte appears on m_data the next cycle.
- Full throughput: with m_ready held high, one byte moves per cycle, with no bubbles between DATA→PAD→FCS.
- Backpressure: m_valid/m_data/m_last hold stable while m_valid && !m_ready. The CRC advances only on load into the output register.
- First byte of PAD is emitted the cycle after s_last is accepted. First FCS byte is emitted the cycle after the final data or pad byte is loaded.
- Back-to-back frames: the first byte of the next frame is accepted no earlier than IFG_CYCLES+1 cycles after the m_last handshake.
- A frame of exactly MIN_DATA bytes goes straight to FCS, with no pad.
- Reset asserted mid-frame aborts the frame immediately. No FCS is emitted and frame_done does not pulse.

## Structure
- Shared package eth_pkg holds:
  - the state enum;
  - CRC32_INIT = 0xFFFFFFFF;
  - CRC32_POLY_REFL = 0xEDB88320;
  - ETH_MIN_DATA = 60;
  - ETH_IFG = 12.
- One sub-module, crc32_d8_next: purely combinational (crc_in[31:0], data[7:0]) → crc_out[31:0]. The controller owns the CRC register, so reset and init follow this block's synchronous active-low scheme.

## Test plan
- Send ASCII "123456789" (9 bytes, s_last on '9'), m_ready=1. Required output:
  - the 9 bytes, then 51 bytes of 0x00, then FCS over the 60 bytes;
  - frame_len=64;
  - FCS checked against a golden zlib model.
- CRC engine unit check: "123456789" with no pad → ~C = 0xCBF43926 (FCS byte order 26 39 F4 CB).
- 60-byte frame, bytes 0x00..0x3B: no pad; 64 bytes out; m_last on byte 64; frame_done one pulse; frame_len=64.
- 100-byte frame with m_ready toggled by a random 50% pattern: output byte sequence is identical to the m_ready=1 run; data is stable whenever m_valid && !m_ready.
- Two back-to-back 60-byte frames with s_valid held high: exactly 12 cycles with m_valid=0 and s_ready=0 between the m_last handshake and the next frame's first output byte.
- rst_n low for 1 cycle at byte 30 of a 60-byte frame: next cycle all outputs are at reset values and no frame_done occurs; a following 60-byte frame produces a correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit frame sequencer.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_t;

   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam int unsigned ETH_MIN_DATA    = 60;
   localparam int unsigned ETH_IFG         = 12;

endpackage

// File: rtl/crc32_d8_next.sv
// One byte step of the reflected CRC-32 (LSB first). Purely combinational;
// the CRC register lives in the controller.
module crc32_d8_next
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] crc_work;

   // fold the byte in, then shift out eight bits against the reflected polynomial
   always_comb begin
      crc_work = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0]) begin
            crc_work = (crc_work >> 1) ^ CRC32_POLY_REFL;
         end else begin
            crc_work = crc_work >> 1;
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Transmit frame sequencer: passes source bytes, zero-pads short frames,
// appends the CRC-32 FCS and enforces the inter-frame gap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for first byte; CRC at init, count 0
// DATA    | forwarding source bytes into the output register and CRC
// PAD     | emitting 0x00 until the minimum data length is reached
// FCS     | emitting the four complemented CRC bytes, LSB first
// IFG     | output idle, down-counting the inter-frame gap
module eth_tx_fcs_ctrl
   import eth_pkg::*;
#(
   parameter int unsigned MIN_DATA   = ETH_MIN_DATA,
   parameter int unsigned IFG_CYCLES = ETH_IFG
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_data,
   output logic        m_last,
   output logic        tx_busy,
   output logic        frame_done,
   output logic [15:0] frame_len
);

   localparam logic [15:0] MIN_LEN  = 16'(MIN_DATA);
   localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);

   tx_state_t   state_q, state_d;
   logic [31:0] crc_q, crc_d, crc_fold, fcs_word;
   logic [15:0] cnt_q, cnt_d, cnt_inc, len_total;
   logic [1:0]  fcs_idx_q, fcs_idx_d;
   logic [7:0]  ifg_q, ifg_d;
   logic [7:0]  crc_byte;
   logic        m_valid_d, m_last_d, frame_done_d;
   logic [7:0]  m_data_d;
   logic [15:0] frame_len_d;
   logic        slot_free, accept;

   assign slot_free = !m_valid || m_ready;
   assign s_ready   = rst_n && slot_free && (state_q == ST_IDLE || state_q == ST_DATA);
   assign accept    = s_valid && s_ready;
   assign tx_busy   = (state_q != ST_IDLE);
   assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign len_total = (cnt_q > 16'hFFFB) ? 16'hFFFF : cnt_q + 16'd4;
   assign fcs_word  = ~crc_q;
   assign crc_byte  = (state_q == ST_PAD) ? 8'h00 : s_data;

   crc32_d8_next u_crc (
      .crc_in  (crc_q),
      .data    (crc_byte),
      .crc_out (crc_fold)
   );

   // next-state and output-register loading; CRC only advances on a load
   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      cnt_d        = cnt_q;
      fcs_idx_d    = fcs_idx_q;
      ifg_d        = ifg_q;
      m_valid_d    = m_valid;
      m_data_d     = m_data;
      m_last_d     = m_last;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len;

      if (slot_free) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE, ST_DATA: begin
            if (accept) begin
               m_valid_d = 1'b1;
               m_data_d  = s_data;
               crc_d     = crc_fold;
               cnt_d     = cnt_inc;
               fcs_idx_d = 2'd0;
               if (s_last) begin
                  state_d = (cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_PAD: begin
            if (slot_free) begin
               m_valid_d = 1'b1;
               m_data_d  = 8'h00;
               crc_d     = crc_fold;
               cnt_d     = cnt_inc;
               fcs_idx_d = 2'd0;
               if (cnt_inc >= MIN_LEN) begin
                  state_d = ST_FCS;
               end
            end
         end
         ST_FCS: begin
            if (m_valid && m_ready && m_last) begin
               state_d      = ST_IFG;
               frame_done_d = 1'b1;
               frame_len_d  = len_total;
               ifg_d        = IFG_LOAD;
            end else if (slot_free) begin
               m_valid_d = 1'b1;
               m_data_d  = fcs_word[{fcs_idx_q, 3'b000} +: 8];
               m_last_d  = (fcs_idx_q == 2'd3);
               fcs_idx_d = fcs_idx_q + 2'd1;
            end
         end
         ST_IFG: begin
            if (ifg_q == 8'd0) begin
               state_d = ST_IDLE;
               crc_d   = CRC32_INIT;
               cnt_d   = 16'd0;
            end else begin
               ifg_d = ifg_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            crc_d   = CRC32_INIT;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // state, CRC and output registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         crc_q      <= CRC32_INIT;
         cnt_q      <= 16'd0;
         fcs_idx_q  <= 2'd0;
         ifg_q      <= 8'd0;
         m_valid    <= 1'b0;
         m_data     <= 8'h00;
         m_last     <= 1'b0;
         frame_done <= 1'b0;
         frame_len  <= 16'd0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         cnt_q      <= cnt_d;
         fcs_idx_q  <= fcs_idx_d;
         ifg_q      <= ifg_d;
         m_valid    <= m_valid_d;
         m_data     <= m_data_d;
         m_last     <= m_last_d;
         frame_done <= frame_done_d;
         frame_len  <= frame_len_d;
      end
   end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Scoreboard bench for eth_tx_fcs_ctrl: expected bytes come from a
// table-driven zlib CRC model; a negedge monitor pops and compares.
module tb_eth_tx_fcs_ctrl;
   import eth_pkg::*;

   localparam int MIN = 60;
   localparam int IFG = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_data = 8'h00;
   logic        s_last = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [7:0]  m_data;
   logic        m_last;
   logic        tx_busy;
   logic        frame_done;
   logic [15:0] frame_len;

   logic [31:0] uc_in, uc_out;
   logic [7:0]  uc_data;

   int tests = 0;
   int fails = 0;
   logic [8:0] exp_q[$];
   int len_q[$];
   int exp_done = 0;
   int done_seen = 0;
   bit ignore = 1'b0;
   bit rdy_rand = 1'b0;
   logic [31:0] crc_tbl[256];
   byte unsigned frm[$];

   bit         stall_prev = 1'b0;
   logic [8:0] stall_word = 9'h0;
   bit         gap_active = 1'b0;
   int         gap_cnt = 0;
   bit         last_hs_prev = 1'b0;

   eth_tx_fcs_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .tx_busy    (tx_busy),
      .frame_done (frame_done),
      .frame_len  (frame_len)
   );

   crc32_d8_next u_crc_unit (
      .crc_in  (uc_in),
      .data    (uc_data),
      .crc_out (uc_out)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] zlib_crc(input byte unsigned b[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) c = crc_tbl[8'(c ^ 32'(b[i]))] ^ (c >> 8);
      return ~c;
   endfunction

   task automatic push_expected();
      byte unsigned p[$];
      logic [31:0] fcs;
      p = frm;
      while (p.size() < MIN) p.push_back(8'h00);
      fcs = zlib_crc(p);
      foreach (p[i]) exp_q.push_back({1'b0, p[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), fcs[8*k +: 8]});
      len_q.push_back(p.size() + 4);
      exp_done++;
   endtask

   task automatic drive_byte(input byte unsigned d, input bit last);
      int t;
      bit acc;
      t = 0;
      acc = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!acc && t < 3000) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) check("src_accept_timeout", 0, 1);
   endtask

   task automatic send(input bit gaps, input bit hold);
      foreach (frm[i]) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         drive_byte(frm[i], (i == frm.size() - 1));
      end
      if (!hold) begin
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || tx_busy || m_valid) && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_queue", exp_q.size(), 0);
   endtask

   // randomised or steady downstream ready, changed just after each edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // monitor: scoreboard pops, hold-stability, gap length and frame_done checks
   always @(negedge clk) begin
      if (frame_done) begin
         done_seen++;
         if (ignore || !rst_n) check("done_during_abort", 1, 0);
      end
      if (!rst_n || ignore) begin
         stall_prev   = 1'b0;
         gap_active   = 1'b0;
         last_hs_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_word", {m_last, m_data}, stall_word);
         end
         stall_prev = m_valid && !m_ready;
         stall_word = {m_last, m_data};
         if (gap_active && m_valid) begin
            check("ifg_gap", gap_cnt, IFG);
            gap_active = 1'b0;
         end else if (gap_active && !s_ready) begin
            gap_cnt++;
         end
         if (frame_done) begin
            check("done_after_last", last_hs_prev, 1);
            if (len_q.size() == 0) check("frame_len_unexpected", frame_len, 0);
            else check("frame_len", frame_len, len_q.pop_front());
         end
         last_hs_prev = m_valid && m_ready && m_last;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("out_unexpected", {m_last, m_data}, 9'h1FF);
            else check("out_byte", {m_last, m_data}, exp_q.pop_front());
            if (m_last) begin
               gap_active = 1'b1;
               gap_cnt    = 0;
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string s;
      logic [31:0] c;
      int n;

      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         crc_tbl[i] = c;
      end

      // standalone CRC step over "123456789"
      s = "123456789";
      uc_in = 32'hFFFF_FFFF;
      uc_data = 8'h00;
      for (int i = 0; i < s.len(); i++) begin
         uc_data = s[i];
         #1;
         uc_in = uc_out;
      end
      check("crc_unit_check", ~uc_in, 32'hCBF4_3926);

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_len", frame_len, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // "123456789" padded to 60
      frm = {};
      for (int i = 0; i < s.len(); i++) frm.push_back(s[i]);
      push_expected();
      send(0, 0);
      wait_idle();
      check("len_short_frame", frame_len, 64);

      // exactly MIN_DATA bytes 0x00..0x3B
      frm = {};
      for (int i = 0; i < 60; i++) frm.push_back(8'(i));
      push_expected();
      send(0, 0);
      wait_idle();
      check("len_min_frame", frame_len, 64);

      // 100 random bytes under random backpressure and source gaps
      rdy_rand = 1'b1;
      frm = {};
      for (int i = 0; i < 100; i++) frm.push_back(8'($urandom));
      push_expected();
      send(1, 0);
      wait_idle();
      rdy_rand = 1'b0;
      check("len_100_frame", frame_len, 104);

      // two back-to-back 60-byte frames with s_valid held high
      frm = {};
      for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
      push_expected();
      send(0, 1);
      frm = {};
      for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
      push_expected();
      send(0, 0);
      wait_idle();

      // reset after byte 30 of a 60-byte frame
      ignore = 1'b1;
      frm = {};
      for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
      for (int i = 0; i < 30; i++) drive_byte(frm[i], 1'b0);
      s_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_s_ready", s_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_m_valid", m_valid, 0);
      check("midrst_m_data", m_data, 0);
      check("midrst_m_last", m_last, 0);
      check("midrst_tx_busy", tx_busy, 0);
      check("midrst_frame_done", frame_done, 0);
      check("midrst_frame_len", frame_len, 0);
      @(posedge clk);
      #1;
      ignore = 1'b0;
      frm = {};
      for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
      push_expected();
      send(0, 0);
      wait_idle();

      // random lengths around the pad boundary and beyond
      for (int f = 0; f < 6; f++) begin
         case (f)
            0: n = 1;
            1: n = 59;
            2: n = 61;
            default: n = $urandom_range(2, 120);
         endcase
         rdy_rand = 1'($urandom_range(0, 1));
         frm = {};
         for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
         push_expected();
         send(1'($urandom_range(0, 1)), 0);
         wait_idle();
      end
      rdy_rand = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("frame_done_count", done_seen, exp_done);
      check("len_queue_empty", len_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
